// File: rtl/cla_adder_8b_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cla_adder_8b_pkg
//  Purpose  : Shared constants for the 8-bit two-level carry-lookahead adder.
//             ADD_WIDTH - full operand width
//             CLA_BLOCK - width of one first-level lookahead block
//  Revision : 1.0 - initial release
// ============================================================================
package cla_adder_8b_pkg;

    localparam int ADD_WIDTH = 8;
    localparam int CLA_BLOCK = 4;

endpackage : cla_adder_8b_pkg
`default_nettype wire

// File: rtl/cla_adder_8b_cla_block_4b.sv
`default_nettype none
// ============================================================================
//  Module   : cla_block_4b
//  Purpose  : 4-bit carry-lookahead block. All internal carries are flat
//             two-level sum-of-products of the per-bit generate/propagate
//             terms and the block carry-in, so no carry ripples between bits.
//  Ports    : a[3:0], b[3:0] - operand nibbles
//             cin            - carry into bit 0 of the block
//             sum[3:0]       - nibble sum
//             gg             - group generate (block produces a carry by itself)
//             gp             - group propagate (block passes cin to its carry-out)
//  Revision : 1.0 - initial release
// ============================================================================
module cla_block_4b
    import cla_adder_8b_pkg::*;
(
    input  logic [CLA_BLOCK-1:0] a,
    input  logic [CLA_BLOCK-1:0] b,
    input  logic                 cin,
    output logic [CLA_BLOCK-1:0] sum,
    output logic                 gg,
    output logic                 gp
);

    logic [CLA_BLOCK-1:0] w_g;
    logic [CLA_BLOCK-1:0] w_p;
    logic [CLA_BLOCK-1:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Carry into each bit, expanded fully from cin.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & cin);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);

    // Group terms exclude cin so the next level can combine blocks directly.
    assign gg = w_g[3]
              | (w_p[3] & w_g[2])
              | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign gp = &w_p;

    assign sum = w_p ^ w_c;

endmodule : cla_block_4b
`default_nettype wire

// File: rtl/cla_adder_8b.sv
`default_nettype none
// ============================================================================
//  Module   : cla_adder_8b
//  Purpose  : 8-bit carry-lookahead adder with registered outputs.
//             {COUT,S} = A + B + CIN, one cycle latency, full throughput.
//             Two 4-bit lookahead blocks are joined by a second-level group
//             lookahead for the nibble carry and the final carry-out.
//  Ports    : clk       - rising-edge clock
//             reset     - asynchronous active-high reset (clears S and COUT)
//             A, B      - unsigned operands
//             CIN       - carry into bit 0
//             S         - registered sum [7:0]
//             COUT      - registered carry-out (bit 8 of the sum)
//  Revision : 1.0 - initial release
// ============================================================================
module cla_adder_8b
    import cla_adder_8b_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH    // only 8 is supported
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] S,
    output logic             COUT
);

    logic [CLA_BLOCK-1:0] w_sum_lo;
    logic [CLA_BLOCK-1:0] w_sum_hi;
    logic                 w_gg0;
    logic                 w_gp0;
    logic                 w_gg1;
    logic                 w_gp1;
    logic                 w_c4;
    logic                 w_cout;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_cout;

    cla_block_4b u_block_lo (
        .a   (A[CLA_BLOCK-1:0]),
        .b   (B[CLA_BLOCK-1:0]),
        .cin (CIN),
        .sum (w_sum_lo),
        .gg  (w_gg0),
        .gp  (w_gp0)
    );

    // Second-level lookahead: the upper block's carry-in comes straight
    // from the lower block's group terms, not from its bit-3 carry.
    assign w_c4 = w_gg0 | (w_gp0 & CIN);

    cla_block_4b u_block_hi (
        .a   (A[ADD_WIDTH-1:CLA_BLOCK]),
        .b   (B[ADD_WIDTH-1:CLA_BLOCK]),
        .cin (w_c4),
        .sum (w_sum_hi),
        .gg  (w_gg1),
        .gp  (w_gp1)
    );

    assign w_cout = w_gg1
                  | (w_gp1 & w_gg0)
                  | (w_gp1 & w_gp0 & CIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= {w_sum_hi, w_sum_lo};
            r_cout <= w_cout;
        end
    end

    assign S    = r_sum;
    assign COUT = r_cout;

endmodule : cla_adder_8b
`default_nettype wire

// File: tb/tb_cla_adder_8b.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cla_adder_8b
//  Purpose  : Self-checking bench for cla_adder_8b. A plain-arithmetic model
//             predicts {COUT,S}; a compare process checks every falling edge,
//             and directed cases pin literal values from the adder's rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cla_adder_8b;

    logic       clk;
    logic       reset;
    logic [7:0] A;
    logic [7:0] B;
    logic       CIN;
    logic [7:0] S;
    logic       COUT;

    int errors = 0;
    int checks = 0;

    logic [8:0] model_q;   // result the DUT must show after the last edge

    cla_adder_8b #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .CIN   (CIN),
        .S     (S),
        .COUT  (COUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic c);
        int total;
        total = int'(a) + int'(b) + int'(c);
        return total[8:0];
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got {COUT,S}=%h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: reset clears at once, otherwise each edge captures A+B+CIN.
    always @(posedge clk or posedge reset) begin
        if (reset) model_q <= 9'h000;
        else       model_q <= ref_sum(A, B, CIN);
    end

    // Continuous comparison away from the active edge.
    always @(negedge clk) begin
        chk("stream", {COUT, S}, reset ? 9'h000 : model_q);
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        A   = a;
        B   = b;
        CIN = c;
    endtask

    task automatic directed(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic c, input logic [8:0] req);
        drive(a, b, c);
        @(posedge clk);
        #1;
        chk(name, {COUT, S}, req);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        reset = 1'b1;
        A     = 8'hAA;
        B     = 8'h55;
        CIN   = 1'b1;

        // Outputs clear without any clock edge.
        #2;
        chk("reset_no_edge", {COUT, S}, 9'h000);

        // Pin the model itself on a few hand-computed values.
        ra = 8'hFF; rb = 8'hFF; rc = 1'b1;
        chk("model_max", ref_sum(ra, rb, rc), 9'h1FF);
        ra = 8'h0F; rb = 8'h00;
        chk("model_nibble", ref_sum(ra, rb, rc), 9'h010);

        // Release reset between edges; the next edge shows AA+55+1.
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("after_release", {COUT, S}, 9'h100);

        directed("zero",        8'h00, 8'h00, 1'b0, 9'h000);
        directed("cin_only",    8'h00, 8'h00, 1'b1, 9'h001);
        directed("nibble_prop", 8'h0F, 8'h00, 1'b1, 9'h010);
        directed("msb_carry",   8'h80, 8'h80, 1'b0, 9'h100);
        directed("max",         8'hFF, 8'hFF, 1'b1, 9'h1FF);
        directed("wrap",        8'hFF, 8'h00, 1'b1, 9'h100);
        directed("alt",         8'h55, 8'hAA, 1'b0, 9'h0FF);

        // Sweep A fully; B/CIN randomised, plus the B extremes for each A.
        for (int a = 0; a < 256; a++) begin
            for (int k = 0; k < 40; k++) begin
                if (k == 0)      rb = 8'h00;
                else if (k == 1) rb = 8'hFF;
                else             rb = 8'($urandom_range(0, 255));
                rc = 1'($urandom_range(0, 1));
                drive(8'(a), rb, rc);

                // Mid-sweep reset pulse between two edges.
                if (a == 128 && k == 7) begin
                    #2 reset = 1'b1;
                    #1 chk("mid_reset_clear", {COUT, S}, 9'h000);
                    #1 reset = 1'b0;
                    @(posedge clk);
                    #1 chk("mid_reset_first", {COUT, S}, ref_sum(8'(a), rb, rc));
                end
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cla_adder_8b
`default_nettype wire
